// File: rtl/multicycle_ctrl_fsm.sv
// Purpose    : Moore controller sequencing fetch/decode/execute/memory/writeback
//              over a shared ALU/memory datapath; counts retired instructions.
// Latency    : branch 3, STR 4, DP 4, LDR 5, Op=11 2 cycles (FETCH included).
// Backpressure: none; the sequence advances every clock, strobes gated by CondEx.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   Op, Funct, Rd     : instruction fields from the IR (ignored during FETCH)
//   CondEx            : condition check passed (combinational, from flags)
//   state             : current state code (debug)
//   IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc
//                     : datapath mux selects / ALU operation
//   PCWrite, RegWrite, MemWrite, FlagWrite
//                     : condition-gated write strobes
//   illegal           : one-cycle pulse in DECODE for unimplemented encodings
//   instret           : retired-instruction counter, wraps modulo 2^CNT_W

module multicycle_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic [3:0]       Rd,
    input  logic             CondEx,
    output logic [3:0]       state,
    output logic             IRWrite,
    output logic             AdrSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUControl,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       RegSrc,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [1:0]       FlagWrite,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    // State encodings. The register is a plain 4-bit vector so that the
    // unused codes 10..15 are representable and fall back to FETCH.
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    logic [3:0]       r_state;
    logic [3:0]       w_next_state;
    logic [CNT_W-1:0] r_instret;
    logic             r_dp_unimpl;   // current DP instruction has no ALU op

    // Moore control fields before gating
    logic             w_nextpc;
    logic             w_irwrite;
    logic             w_aluop;
    logic             w_regw;
    logic             w_memw;
    logic             w_branch;
    logic             w_pcs;
    logic [1:0]       w_flagw;

    // Funct[4:1] decode shared by the ALU decoder and the illegal check
    logic             w_funct_impl;
    logic             w_funct_arith;
    logic             w_retire;

    assign w_funct_impl  = (Funct[4:1] == 4'b0100) || (Funct[4:1] == 4'b0010) ||
                           (Funct[4:1] == 4'b0000) || (Funct[4:1] == 4'b1100);
    assign w_funct_arith = (Funct[4:1] == 4'b0100) || (Funct[4:1] == 4'b0010);

    // Every state that ends an instruction transitions unconditionally to
    // FETCH, so being in one of them means the next edge retires it.
    assign w_retire = (r_state == S_MEMWB) || (r_state == S_MEMWR) ||
                      (r_state == S_ALUWB) || (r_state == S_BRANCH);

    assign state   = r_state;
    assign instret = r_instret;

    //--------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    //--------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b01:   w_next_state = S_MEMADR;
                    2'b00:   w_next_state = Funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   w_next_state = S_BRANCH;
                    default: w_next_state = S_FETCH;   // Op=11: dropped
                endcase
            end
            S_MEMADR: w_next_state = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next_state = S_MEMWB;
            S_EXECR:  w_next_state = S_ALUWB;
            S_EXECI:  w_next_state = S_ALUWB;
            default:  w_next_state = S_FETCH;   // MEMWB/MEMWR/ALUWB/BRANCH, 10..15
        endcase
    end

    //--------------------------------------------------------------------
    // Output logic: Moore fields, ALU decode, then condition/reset gating
    //--------------------------------------------------------------------
    always_comb begin
        w_irwrite  = 1'b0;
        w_nextpc   = 1'b0;
        w_aluop    = 1'b0;
        w_regw     = 1'b0;
        w_memw     = 1'b0;
        w_branch   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;

        case (r_state)
            S_FETCH: begin
                w_irwrite = 1'b1;
                w_nextpc  = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                w_regw    = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                w_memw = 1'b1;
            end
            S_EXECR: begin
                w_aluop = 1'b1;
                ALUSrcB = 2'b00;
            end
            S_EXECI: begin
                w_aluop = 1'b1;
                ALUSrcB = 2'b01;
            end
            S_ALUWB:  w_regw = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_branch  = 1'b1;
            end
            default: ;
        endcase

        // ALU operation; unknown Funct codes fall back to ADD
        ALUControl = 2'b00;
        w_flagw    = 2'b00;
        if (w_aluop) begin
            case (Funct[4:1])
                4'b0100: ALUControl = 2'b00;
                4'b0010: ALUControl = 2'b01;
                4'b0000: ALUControl = 2'b10;
                4'b1100: ALUControl = 2'b11;
                default: ALUControl = 2'b00;
            endcase
            w_flagw[1] = Funct[0];
            w_flagw[0] = Funct[0] & w_funct_arith;
        end

        // An unimplemented DP op still walks EXEC/ALUWB for uniform timing but
        // must not change architectural state; dropping RegW also keeps a
        // bogus result from being written to the PC.
        if (r_dp_unimpl) begin
            w_flagw = 2'b00;
            w_regw  = 1'b0;
        end

        w_pcs = ((Rd == 4'hF) && w_regw) || w_branch;

        ImmSrc    = Op;
        RegSrc    = {(Op == 2'b01), (Op == 2'b10)};

        IRWrite   = w_irwrite & ~reset;
        PCWrite   = (w_nextpc | (w_pcs & CondEx)) & ~reset;
        RegWrite  = w_regw & CondEx & (Rd != 4'hF) & ~reset;
        MemWrite  = w_memw & CondEx & ~reset;
        FlagWrite = w_flagw & {2{CondEx & ~reset}};
        illegal   = (r_state == S_DECODE) && !reset &&
                    ((Op == 2'b11) || ((Op == 2'b00) && !w_funct_impl));
    end

    //--------------------------------------------------------------------
    // Unimplemented-DP marker, captured in DECODE and held through the
    // following EXEC/ALUWB states of the same instruction.
    //--------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dp_unimpl <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_dp_unimpl <= (Op == 2'b00) && !w_funct_impl;
        end
    end

    //--------------------------------------------------------------------
    // Retired-instruction counter (wraps naturally)
    //--------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Purpose    : scoreboard bench for multicycle_ctrl_fsm (narrow counter to hit wrap).
// Latency    : one expected entry per clock, compared on the falling edge.
// Backpressure: n/a.

module tb_multicycle_ctrl_fsm;

    localparam int TB_CNT_W = 3;

    logic                clk;
    logic                reset;
    logic [1:0]          Op;
    logic [5:0]          Funct;
    logic [3:0]          Rd;
    logic                CondEx;
    logic [3:0]          state;
    logic                IRWrite;
    logic                AdrSrc;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          ResultSrc;
    logic [1:0]          ALUControl;
    logic [1:0]          ImmSrc;
    logic [1:0]          RegSrc;
    logic                PCWrite;
    logic                RegWrite;
    logic                MemWrite;
    logic [1:0]          FlagWrite;
    logic                illegal;
    logic [TB_CNT_W-1:0] instret;

    multicycle_ctrl_fsm #(.CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .CondEx     (CondEx),
        .state      (state),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .FlagWrite  (FlagWrite),
        .illegal    (illegal),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected per-cycle observation.
    // strb = {IRWrite, PCWrite, RegWrite, MemWrite, FlagWrite[1:0], illegal}
    typedef struct packed {
        logic [3:0]  st;
        logic [6:0]  strb;
        logic [1:0]  alu;
        logic [31:0] ret;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_ret = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    // Static mux selects per state: {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}
    function automatic logic [5:0] mux_of(input logic [3:0] st);
        case (st)
            4'd0:    mux_of = 6'b0_1_10_10;
            4'd1:    mux_of = 6'b0_1_10_10;
            4'd2:    mux_of = 6'b0_0_01_00;
            4'd3:    mux_of = 6'b1_0_00_00;
            4'd4:    mux_of = 6'b0_0_00_01;
            4'd5:    mux_of = 6'b1_0_00_00;
            4'd6:    mux_of = 6'b0_0_00_00;
            4'd7:    mux_of = 6'b0_0_01_00;
            4'd8:    mux_of = 6'b0_0_00_00;
            4'd9:    mux_of = 6'b0_0_01_10;
            default: mux_of = 6'b0;
        endcase
    endfunction

    task automatic push(input logic [3:0] st, input logic [6:0] strb, input logic [1:0] alu);
        exp_t e;
        e.st   = st;
        e.strb = strb;
        e.alu  = alu;
        e.ret  = 32'(exp_ret % (1 << TB_CNT_W));
        exp_q.push_back(e);
    endtask

    task automatic check_cycle();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("state", 32'(state), 32'(e.st));
            chk("strobes", 32'({IRWrite, PCWrite, RegWrite, MemWrite, FlagWrite, illegal}),
                32'(e.strb));
            chk("mux", 32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}),
                32'({mux_of(e.st), e.alu}));
            chk("instret", 32'(instret), e.ret);
            chk("src", 32'({ImmSrc, RegSrc}), 32'({Op, (Op == 2'b01), (Op == 2'b10)}));
        end
    endtask

    // Runs n cycles of one instruction; inputs change just after the edge
    // into FETCH. rst_at >= 0 asserts reset from that cycle on.
    task automatic run(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                       input logic c, input int n, input int rst_at);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                Op     = op;
                Funct  = f;
                Rd     = rd;
                CondEx = c;
                reset  = 1'b0;
            end
            if (i == rst_at) reset = 1'b1;
            @(negedge clk);
            check_cycle();
        end
    endtask

    localparam logic [6:0] F_STRB = 7'b1100000;   // FETCH: IRWrite + PCWrite

    initial begin
        reset  = 1'b1;
        Op     = 2'b00;
        Funct  = 6'b0;
        Rd     = 4'b0;
        CondEx = 1'b0;

        // Reset held: FETCH, all strobes off, counter cleared
        exp_ret = 0;
        push(4'd0, 7'b0, 2'b00);
        push(4'd0, 7'b0, 2'b00);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_cycle();
        end

        // ADDS R1, reg: flags in EXECR, write in ALUWB
        push(4'd0, F_STRB, 2'b00); push(4'd1, 7'b0, 2'b00);
        push(4'd6, 7'b0000110, 2'b00); push(4'd8, 7'b0010000, 2'b00);
        run(2'b00, 6'b001001, 4'd1, 1'b1, 4, -1);
        exp_ret++;

        // LDR
        push(4'd0, F_STRB, 2'b00); push(4'd1, 7'b0, 2'b00); push(4'd2, 7'b0, 2'b00);
        push(4'd3, 7'b0, 2'b00); push(4'd4, 7'b0010000, 2'b00);
        run(2'b01, 6'b011001, 4'd2, 1'b1, 5, -1);
        exp_ret++;

        // STR with condition failed: no MemWrite, still retires
        push(4'd0, F_STRB, 2'b00); push(4'd1, 7'b0, 2'b00); push(4'd2, 7'b0, 2'b00);
        push(4'd5, 7'b0, 2'b00);
        run(2'b01, 6'b011000, 4'd3, 1'b0, 4, -1);
        exp_ret++;

        // B taken
        push(4'd0, F_STRB, 2'b00); push(4'd1, 7'b0, 2'b00); push(4'd9, 7'b0100000, 2'b00);
        run(2'b10, 6'b101000, 4'd0, 1'b1, 3, -1);
        exp_ret++;

        // B not taken
        push(4'd0, F_STRB, 2'b00); push(4'd1, 7'b0, 2'b00); push(4'd9, 7'b0, 2'b00);
        run(2'b10, 6'b101000, 4'd0, 1'b0, 3, -1);
        exp_ret++;

        // ORR to R15 (register form, no S): PC write instead of reg write
        push(4'd0, F_STRB, 2'b00); push(4'd1, 7'b0, 2'b00);
        push(4'd6, 7'b0, 2'b11); push(4'd8, 7'b0100000, 2'b00);
        run(2'b00, 6'b011000, 4'd15, 1'b1, 4, -1);
        exp_ret++;

        // Op=11: illegal pulse, straight back to FETCH, not retired
        push(4'd0, F_STRB, 2'b00); push(4'd1, 7'b0000001, 2'b00);
        run(2'b11, 6'b000000, 4'd0, 1'b1, 2, -1);

        // SUBS immediate with condition failed: no flags, no write
        push(4'd0, F_STRB, 2'b00); push(4'd1, 7'b0, 2'b00);
        push(4'd7, 7'b0, 2'b01); push(4'd8, 7'b0, 2'b00);
        run(2'b00, 6'b100101, 4'd4, 1'b0, 4, -1);
        exp_ret++;

        // ANDS reg: only NZ flags; counter wraps after this one
        push(4'd0, F_STRB, 2'b00); push(4'd1, 7'b0, 2'b00);
        push(4'd6, 7'b0000100, 2'b10); push(4'd8, 7'b0010000, 2'b00);
        run(2'b00, 6'b000001, 4'd4, 1'b1, 4, -1);
        exp_ret++;

        // Unimplemented DP (Funct[4:1]=0111, S=1): illegal, no flags, no write
        push(4'd0, F_STRB, 2'b00); push(4'd1, 7'b0000001, 2'b00);
        push(4'd6, 7'b0, 2'b00); push(4'd8, 7'b0, 2'b00);
        run(2'b00, 6'b001111, 4'd5, 1'b1, 4, -1);
        exp_ret++;

        // LDR abandoned by reset in MEMRD
        push(4'd0, F_STRB, 2'b00); push(4'd1, 7'b0, 2'b00); push(4'd2, 7'b0, 2'b00);
        push(4'd3, 7'b0, 2'b00);
        exp_ret = 0;
        push(4'd0, 7'b0, 2'b00);
        run(2'b01, 6'b011001, 4'd2, 1'b1, 5, 3);

        // First instruction after reset release
        push(4'd0, F_STRB, 2'b00); push(4'd1, 7'b0, 2'b00); push(4'd9, 7'b0100000, 2'b00);
        run(2'b10, 6'b101000, 4'd0, 1'b1, 3, -1);
        exp_ret++;

        push(4'd0, F_STRB, 2'b00); push(4'd1, 7'b0000001, 2'b00);
        run(2'b11, 6'b000000, 4'd0, 1'b1, 2, -1);

        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
